idecode_pipe: RTL and testbench
===============================

// Module: idecode_pipe
// PURPOSE
//  Elastic RV32/RV64 decode stage. Replaces the fixed-stall decode stage with a
//  valid/ready handshake on both sides. Optional M-extension and RV64 W-op decode.
//  Sits between fetch (upstream) and execute (downstream).
//  Holds a 2-entry skid buffer so in_ready is a register output, with no
//  combinational path from out_ready.
// PARAMETERS
//  XLEN       64  datapath width; legal values 32 or 64
//  SUPPORT_M  1   1 = decode MUL/DIV/REM; 0 = these encodings trap as illegal
// PORTS
//  clk              in   1     clock, rising edge
//  resetn           in   1     asynchronous reset, active low
//  flush            in   1     discard all held instructions (branch/trap redirect)
//  in_valid         in   1     instr/pc valid
//  in_ready         out  1     stage can accept this cycle
//  instr            in   32    raw instruction
//  pc               in   XLEN  instruction address
//  out_valid        out  1     decoded bundle valid
//  out_ready        in   1     execute accepts bundle
//  opcode           out  7     instr[6:0]
//  funct3           out  3     instr[14:12]
//  funct7           out  7     instr[31:25]
//  rd,rs1,rs2       out  5     register indices
//  imm              out  XLEN  sign-extended immediate (I/S/B/U/J by format)
//  pc_out           out  XLEN  pc of the bundle
//  alu_op           out  4     0 none,1 ADD,2 SUB,3 OR,4 AND,5 XOR,6 SLL,7 SRL,8 SRA,
//                              9 SLT,10 SLTU,11 MUL*,12 MULH*,13 DIV*,14 REM*
//                              (*signedness from funct3)
//  is_word          out  1     RV64 W-op: execute truncates to 32 bits, then sign-extends
//  csr_addr         out  12    instr[31:20]
//  is_csr,csr_read,csr_write  out 1  CSR controls
//  reg_write_enable,mem_read,mem_write,is_branch,jump,use_pc  out 1  controls
//  trap             out  1     bundle raises exception
//  trap_cause       out  4     2 illegal, 3 EBREAK, 11 ECALL
// BEHAVIOUR
//  Decode is combinational on instr/pc. The result is registered into OUT or SKID.
//  Latency is 1 cycle from the accepting edge to out_valid.
//  Transfer: in accepted when in_valid&in_ready; out consumed when out_valid&out_ready.
//  in_ready = ~skid_valid (registered).
//  Accept while OUT is held (out_valid & ~out_ready) -> bundle goes to SKID.
//  When OUT is consumed: SKID moves to OUT if skid_valid, else a new accept goes to OUT.
//  Accept + consume in the same cycle with SKID empty -> new bundle to OUT. No bubble.
//  Order is strictly preserved. Sustained throughput: 1 instruction per cycle.
//  flush: next edge clears out_valid and skid_valid, and sets all OUT controls to 0.
//    A same-cycle input is dropped.
//  Reset (async): out_valid=0, skid_valid=0, in_ready=1, every output register 0.
//  Control decode:
//    OP/OP-IMM: reg_wr=1; alu_op per funct3/funct7.
//      SUB and SRA need funct7=0100000; other funct7 values are illegal.
//    OP-32/OP-IMM-32 (0111011/0011011): is_word=1. Illegal when XLEN=32.
//    Shift-imm: shamt bit 5 set with XLEN=32 -> illegal.
//    funct7=0000001 on OP/OP-32: M op; illegal if SUPPORT_M=0.
//    LOAD: mem_read,reg_wr,ADD. STORE: mem_write,ADD. BRANCH: is_branch, alu_op 0.
//    JAL: jump,reg_wr,use_pc,ADD. JALR: jump,reg_wr,ADD.
//    LUI: reg_wr, alu_op 0. AUIPC: reg_wr,use_pc,ADD.
//    LD/SD/LWU with XLEN=32 -> illegal.
//    SYSTEM funct3!=0: is_csr, csr_read=(rd!=0 | funct3[1]), csr_write=(funct3[1:0]==01 | rs1!=0).
//      reg_wr=(rd!=0). funct3=100 is illegal.
//    SYSTEM funct3=0: ECALL/EBREAK trap cause 11/3. MRET is passed with jump=1.
//      Any other encoding is illegal.
//    Any unlisted opcode, or instr[1:0]!=11 -> illegal.
//  Trap priority: a bundle with trap=1 has reg_wr, mem_read, mem_write, is_branch, jump,
//    is_csr all 0 and alu_op=0.
// TESTING
//  1 Reset mid-stream with SKID full -> out_valid=0, in_ready=1 immediately; outputs 0.
//  2 Stream ADD,SUB,XOR with out_ready=1 -> alu_op 1,2,5 on 3 consecutive cycles;
//    in_ready stays 1.
//  3 Hold out_ready=0 and feed ADDI x1,x2,100 then LW x1,8(x2) -> ADDI held in OUT,
//    LW in SKID, in_ready=0; release -> imm 0x64 then 0x8, no loss.
//  4 flush with SKID full and in_valid=1 -> next cycle out_valid=0, all controls 0.
//  5 XLEN=32: ADDW (0x002080BB), SLLI shamt=32, LD -> trap=1, cause 2.
//    XLEN=64: ADDW -> is_word=1, alu_op 1.
//  6 SUPPORT_M=0 MUL (0x022080B3) -> illegal trap.
//    ECALL -> trap cause 11. CSRRS x0,0x300,x0 -> csr_read=1, csr_write=0, reg_wr=0.

Source files
------------

// File: rtl/idecode_pipe.sv
// Elastic RV32/RV64 decode stage between fetch and execute.
// Instructions are decoded combinationally and registered into OUT, or into a
// one-entry SKID register when OUT is stalled, so in_ready depends only on state.
module idecode_pipe #(
  parameter int XLEN      = 64,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [3:0]      alu_op,
  output logic            is_word,
  output logic [11:0]     csr_addr,
  output logic            is_csr,
  output logic            csr_read,
  output logic            csr_write,
  output logic            reg_write_enable,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            jump,
  output logic            use_pc,
  output logic            trap,
  output logic [3:0]      trap_cause
);

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB = 4'd2,  ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,  ALU_XOR  = 4'd5,  ALU_SLL = 4'd6,  ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,  ALU_SLT  = 4'd9,  ALU_SLTU = 4'd10, ALU_MUL = 4'd11,
    ALU_MULH = 4'd12, ALU_DIV  = 4'd13, ALU_REM = 4'd14
  } alu_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  localparam bit IS_RV32 = (XLEN == 32);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_op;
    logic            is_word;
    logic [11:0]     csr_addr;
    logic            is_csr;
    logic            csr_read;
    logic            csr_write;
    logic            reg_write_enable;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            jump;
    logic            use_pc;
    logic            trap;
    logic [3:0]      trap_cause;
  } bundle_t;

  // Register-register / register-immediate ALU selection for funct7 = 0.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // M-extension selection; execute recovers signedness from funct3.
  function automatic logic [3:0] m_alu(input logic [2:0] f3);
    case (f3)
      3'b000:         m_alu = ALU_MUL;
      3'b100, 3'b101: m_alu = ALU_DIV;
      3'b110, 3'b111: m_alu = ALU_REM;
      default:        m_alu = ALU_MULH;
    endcase
  endfunction

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  bundle_t     dec;
  logic        illegal;
  logic [63:0] imm_sel;

  // Combinational decode of the incoming instruction into a full bundle.
  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    imm_sel      = '0;
    dec.opcode   = instr[6:0];
    dec.funct3   = f3;
    dec.funct7   = f7;
    dec.rd       = instr[11:7];
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.pc       = pc;
    dec.csr_addr = instr[31:20];

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OP: begin
          dec.reg_write_enable = 1'b1;
          case (f7)
            7'b0000000: dec.alu_op = base_alu(f3);
            7'b0100000: begin
              if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
              else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
              else                   illegal = 1'b1;
            end
            7'b0000001: begin
              if (SUPPORT_M) dec.alu_op = m_alu(f3);
              else           illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
        OPC_OP_IMM: begin
          dec.reg_write_enable = 1'b1;
          imm_sel = imm_i;
          case (f3)
            3'b001: begin
              dec.alu_op = ALU_SLL;
              if (instr[31:26] != 6'b000000) illegal = 1'b1;
              if (IS_RV32 && instr[25])      illegal = 1'b1;
            end
            3'b101: begin
              if (instr[31:26] == 6'b000000)      dec.alu_op = ALU_SRL;
              else if (instr[31:26] == 6'b010000) dec.alu_op = ALU_SRA;
              else                                illegal = 1'b1;
              if (IS_RV32 && instr[25]) illegal = 1'b1;
            end
            default: dec.alu_op = base_alu(f3);
          endcase
        end
        OPC_OP_IMM_32: begin
          dec.reg_write_enable = 1'b1;
          dec.is_word = 1'b1;
          imm_sel = imm_i;
          if (IS_RV32) illegal = 1'b1;
          case (f3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: begin
              if (f7 == 7'b0000000) dec.alu_op = ALU_SLL;
              else                  illegal = 1'b1;
            end
            3'b101: begin
              if (f7 == 7'b0000000)      dec.alu_op = ALU_SRL;
              else if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
              else                       illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
        OPC_OP_32: begin
          dec.reg_write_enable = 1'b1;
          dec.is_word = 1'b1;
          if (IS_RV32) illegal = 1'b1;
          case (f7)
            7'b0000000: begin
              if (f3 == 3'b000)      dec.alu_op = ALU_ADD;
              else if (f3 == 3'b001) dec.alu_op = ALU_SLL;
              else if (f3 == 3'b101) dec.alu_op = ALU_SRL;
              else                   illegal = 1'b1;
            end
            7'b0100000: begin
              if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
              else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
              else                   illegal = 1'b1;
            end
            7'b0000001: begin
              if (!SUPPORT_M || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)
                illegal = 1'b1;
              else
                dec.alu_op = m_alu(f3);
            end
            default: illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec.mem_read = 1'b1;
          dec.reg_write_enable = 1'b1;
          dec.alu_op = ALU_ADD;
          imm_sel = imm_i;
          if (f3 == 3'b111)                               illegal = 1'b1;
          if (IS_RV32 && (f3 == 3'b011 || f3 == 3'b110)) illegal = 1'b1;
        end
        OPC_STORE: begin
          dec.mem_write = 1'b1;
          dec.alu_op = ALU_ADD;
          imm_sel = imm_s;
          if (f3[2])                     illegal = 1'b1;
          if (IS_RV32 && f3 == 3'b011) illegal = 1'b1;
        end
        OPC_BRANCH: begin
          dec.is_branch = 1'b1;
          imm_sel = imm_b;
          if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
        end
        OPC_JAL: begin
          dec.jump = 1'b1;
          dec.reg_write_enable = 1'b1;
          dec.use_pc = 1'b1;
          dec.alu_op = ALU_ADD;
          imm_sel = imm_j;
        end
        OPC_JALR: begin
          dec.jump = 1'b1;
          dec.reg_write_enable = 1'b1;
          dec.alu_op = ALU_ADD;
          imm_sel = imm_i;
          if (f3 != 3'b000) illegal = 1'b1;
        end
        OPC_LUI: begin
          dec.reg_write_enable = 1'b1;
          imm_sel = imm_u;
        end
        OPC_AUIPC: begin
          dec.reg_write_enable = 1'b1;
          dec.use_pc = 1'b1;
          dec.alu_op = ALU_ADD;
          imm_sel = imm_u;
        end
        OPC_SYSTEM: begin
          imm_sel = imm_i;
          if (f3 == 3'b000) begin
            if (instr == INSTR_ECALL) begin
              dec.trap = 1'b1;
              dec.trap_cause = 4'd11;
            end else if (instr == INSTR_EBREAK) begin
              dec.trap = 1'b1;
              dec.trap_cause = 4'd3;
            end else if (instr == INSTR_MRET) begin
              dec.jump = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end else if (f3 == 3'b100) begin
            illegal = 1'b1;
          end else begin
            dec.is_csr = 1'b1;
            dec.csr_read = (instr[11:7] != 5'd0) || f3[1];
            dec.csr_write = (f3[1:0] == 2'b01) || (instr[19:15] != 5'd0);
            dec.reg_write_enable = (instr[11:7] != 5'd0);
          end
        end
        default: illegal = 1'b1;
      endcase
    end

    dec.imm = imm_sel[XLEN-1:0];

    if (illegal) begin
      dec.trap = 1'b1;
      dec.trap_cause = 4'd2;
    end

    // A trapping bundle must not cause any architectural side effect.
    if (dec.trap) begin
      dec.alu_op = ALU_NONE;
      dec.is_word = 1'b0;
      dec.is_csr = 1'b0;
      dec.csr_read = 1'b0;
      dec.csr_write = 1'b0;
      dec.reg_write_enable = 1'b0;
      dec.mem_read = 1'b0;
      dec.mem_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.jump = 1'b0;
      dec.use_pc = 1'b0;
    end
  end

  bundle_t out_q;
  bundle_t skid_q;
  logic    skid_valid;
  logic    accept;
  logic    out_free;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  // OUT/SKID handshake: OUT refills from SKID first, otherwise from the input;
  // an accept while OUT is stalled parks the bundle in SKID.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign opcode           = out_q.opcode;
  assign funct3           = out_q.funct3;
  assign funct7           = out_q.funct7;
  assign rd               = out_q.rd;
  assign rs1              = out_q.rs1;
  assign rs2              = out_q.rs2;
  assign imm              = out_q.imm;
  assign pc_out           = out_q.pc;
  assign alu_op           = out_q.alu_op;
  assign is_word          = out_q.is_word;
  assign csr_addr         = out_q.csr_addr;
  assign is_csr           = out_q.is_csr;
  assign csr_read         = out_q.csr_read;
  assign csr_write        = out_q.csr_write;
  assign reg_write_enable = out_q.reg_write_enable;
  assign mem_read         = out_q.mem_read;
  assign mem_write        = out_q.mem_write;
  assign is_branch        = out_q.is_branch;
  assign jump             = out_q.jump;
  assign use_pc           = out_q.use_pc;
  assign trap             = out_q.trap;
  assign trap_cause       = out_q.trap_cause;

endmodule

// File: tb/tb_idecode_pipe.sv
// Directed bench for idecode_pipe. Three instances share the input side:
// index 0 = RV64 with M, index 1 = RV64 without M, index 2 = RV32 with M.
module tb_idecode_pipe;

  localparam logic [31:0] I_ADD    = 32'h0020_81B3;
  localparam logic [31:0] I_SUB    = 32'h4020_81B3;
  localparam logic [31:0] I_XOR    = 32'h0020_C1B3;
  localparam logic [31:0] I_ADDI   = 32'h0641_0093;
  localparam logic [31:0] I_LW     = 32'h0081_2083;
  localparam logic [31:0] I_ADDW   = 32'h0020_80BB;
  localparam logic [31:0] I_SLLI32 = 32'h0201_1093;
  localparam logic [31:0] I_LD     = 32'h0081_3083;
  localparam logic [31:0] I_MUL    = 32'h0220_80B3;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_CSRRS  = 32'h3000_2073;
  localparam logic [31:0] I_JAL    = 32'h0080_00EF;
  localparam logic [31:0] I_BEQ    = 32'hFE20_8EE3;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        in_ready [3];
  logic        out_valid [3];
  logic [6:0]  opcode [3];
  logic [2:0]  funct3 [3];
  logic [6:0]  funct7 [3];
  logic [4:0]  rd [3];
  logic [4:0]  rs1 [3];
  logic [4:0]  rs2 [3];
  logic [3:0]  alu_op [3];
  logic        is_word [3];
  logic [11:0] csr_addr [3];
  logic        is_csr [3];
  logic        csr_read [3];
  logic        csr_write [3];
  logic        reg_wr [3];
  logic        mem_read [3];
  logic        mem_write [3];
  logic        is_branch [3];
  logic        jump [3];
  logic        use_pc [3];
  logic        trap [3];
  logic [3:0]  trap_cause [3];
  logic [63:0] imm [2];
  logic [63:0] pc_out [2];
  logic [31:0] imm_32, pc_out_32;

  int checks = 0;
  int failures = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  idecode_pipe #(.XLEN(64), .SUPPORT_M(1'b1)) dut64 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .instr(instr), .pc(pc), .out_valid(out_valid[0]), .out_ready(out_ready),
    .opcode(opcode[0]), .funct3(funct3[0]), .funct7(funct7[0]), .rd(rd[0]), .rs1(rs1[0]),
    .rs2(rs2[0]), .imm(imm[0]), .pc_out(pc_out[0]), .alu_op(alu_op[0]), .is_word(is_word[0]),
    .csr_addr(csr_addr[0]), .is_csr(is_csr[0]), .csr_read(csr_read[0]), .csr_write(csr_write[0]),
    .reg_write_enable(reg_wr[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .is_branch(is_branch[0]), .jump(jump[0]), .use_pc(use_pc[0]), .trap(trap[0]),
    .trap_cause(trap_cause[0])
  );

  idecode_pipe #(.XLEN(64), .SUPPORT_M(1'b0)) dut_nom (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .instr(instr), .pc(pc), .out_valid(out_valid[1]), .out_ready(out_ready),
    .opcode(opcode[1]), .funct3(funct3[1]), .funct7(funct7[1]), .rd(rd[1]), .rs1(rs1[1]),
    .rs2(rs2[1]), .imm(imm[1]), .pc_out(pc_out[1]), .alu_op(alu_op[1]), .is_word(is_word[1]),
    .csr_addr(csr_addr[1]), .is_csr(is_csr[1]), .csr_read(csr_read[1]), .csr_write(csr_write[1]),
    .reg_write_enable(reg_wr[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .is_branch(is_branch[1]), .jump(jump[1]), .use_pc(use_pc[1]), .trap(trap[1]),
    .trap_cause(trap_cause[1])
  );

  idecode_pipe #(.XLEN(32), .SUPPORT_M(1'b1)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[2]),
    .instr(instr), .pc(pc[31:0]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .opcode(opcode[2]), .funct3(funct3[2]), .funct7(funct7[2]), .rd(rd[2]), .rs1(rs1[2]),
    .rs2(rs2[2]), .imm(imm_32), .pc_out(pc_out_32), .alu_op(alu_op[2]), .is_word(is_word[2]),
    .csr_addr(csr_addr[2]), .is_csr(is_csr[2]), .csr_read(csr_read[2]), .csr_write(csr_write[2]),
    .reg_write_enable(reg_wr[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .is_branch(is_branch[2]), .jump(jump[2]), .use_pc(use_pc[2]), .trap(trap[2]),
    .trap_cause(trap_cause[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting cycle with execute ready.
  task automatic send(input logic [31:0] i, input logic [63:0] p);
    in_valid = 1'b1;
    out_ready = 1'b1;
    instr = i;
    pc = p;
    tick();
    in_valid = 1'b0;
  endtask

  // Stall execute and push ADDI then LW so ADDI sits in OUT and LW in SKID.
  task automatic fill_skid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = I_ADDI;
    pc = 64'h100;
    tick();
    instr = I_LW;
    pc = 64'h104;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready[0]); end
    checks++; if (in_ready[2] !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready32 got=%0b exp=1", in_ready[2]); end
    checks++; if (alu_op[0] !== 4'd0) begin failures++; $display("[TB] FAIL reset_alu_op got=%0d exp=0", alu_op[0]); end
    checks++; if (imm[0] !== 64'd0) begin failures++; $display("[TB] FAIL reset_imm got=%0h exp=0", imm[0]); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] seq [3];
    logic [3:0]  exp_alu [3];
    seq = '{I_ADD, I_SUB, I_XOR};
    exp_alu = '{4'd1, 4'd2, 4'd5};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = seq[k];
      pc = 64'h200 + 64'(4 * k);
      tick();
      checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid[%0d] got=%0b exp=1", k, out_valid[0]); end
      checks++; if (alu_op[0] !== exp_alu[k]) begin failures++; $display("[TB] FAIL stream_alu[%0d] got=%0d exp=%0d", k, alu_op[0], exp_alu[k]); end
      checks++; if (pc_out[0] !== 64'h200 + 64'(4 * k)) begin failures++; $display("[TB] FAIL stream_pc[%0d] got=%0h exp=%0h", k, pc_out[0], 64'h200 + 64'(4 * k)); end
      checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d] got=%0b exp=1", k, in_ready[0]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain got=%0b exp=0", out_valid[0]); end
  endtask

  task automatic test_skid();
    fill_skid();
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("[TB] FAIL skid_in_ready got=%0b exp=0", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL skid_out_valid got=%0b exp=1", out_valid[0]); end
    checks++; if (imm[0] !== 64'h64) begin failures++; $display("[TB] FAIL skid_held_imm got=%0h exp=64", imm[0]); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL skid_move_valid got=%0b exp=1", out_valid[0]); end
    checks++; if (imm[0] !== 64'h8) begin failures++; $display("[TB] FAIL skid_move_imm got=%0h exp=8", imm[0]); end
    checks++; if (pc_out[0] !== 64'h104) begin failures++; $display("[TB] FAIL skid_move_pc got=%0h exp=104", pc_out[0]); end
    checks++; if (mem_read[0] !== 1'b1) begin failures++; $display("[TB] FAIL skid_move_mem_read got=%0b exp=1", mem_read[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("[TB] FAIL skid_move_in_ready got=%0b exp=1", in_ready[0]); end
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL skid_drain got=%0b exp=0", out_valid[0]); end
  endtask

  task automatic test_flush();
    fill_skid();
    flush = 1'b1;
    in_valid = 1'b1;
    instr = I_ADD;
    pc = 64'h300;
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid got=%0b exp=0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready got=%0b exp=1", in_ready[0]); end
    checks++; if (reg_wr[0] !== 1'b0) begin failures++; $display("[TB] FAIL flush_reg_wr got=%0b exp=0", reg_wr[0]); end
    checks++; if (alu_op[0] !== 4'd0) begin failures++; $display("[TB] FAIL flush_alu_op got=%0d exp=0", alu_op[0]); end
    checks++; if (mem_read[0] !== 1'b0) begin failures++; $display("[TB] FAIL flush_mem_read got=%0b exp=0", mem_read[0]); end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL flush_dropped got=%0b exp=0", out_valid[0]); end
  endtask

  task automatic test_reset_midstream();
    fill_skid();
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_full got=%0b exp=0", in_ready[0]); end
    resetn = 1'b0;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid got=%0b exp=0", out_valid[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_ready got=%0b exp=1", in_ready[0]); end
    checks++; if (imm[0] !== 64'd0) begin failures++; $display("[TB] FAIL midrst_imm got=%0h exp=0", imm[0]); end
    checks++; if (pc_out[0] !== 64'd0) begin failures++; $display("[TB] FAIL midrst_pc got=%0h exp=0", pc_out[0]); end
    checks++; if (reg_wr[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrst_reg_wr got=%0b exp=0", reg_wr[0]); end
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_xlen();
    send(I_ADDW, 64'h400);
    checks++; if (trap[2] !== 1'b1 || trap_cause[2] !== 4'd2) begin failures++; $display("[TB] FAIL rv32_addw trap=%0b cause=%0d exp trap=1 cause=2", trap[2], trap_cause[2]); end
    checks++; if (reg_wr[2] !== 1'b0) begin failures++; $display("[TB] FAIL rv32_addw_reg_wr got=%0b exp=0", reg_wr[2]); end
    checks++; if (is_word[0] !== 1'b1 || alu_op[0] !== 4'd1) begin failures++; $display("[TB] FAIL rv64_addw is_word=%0b alu=%0d exp 1/1", is_word[0], alu_op[0]); end
    checks++; if (trap[0] !== 1'b0) begin failures++; $display("[TB] FAIL rv64_addw_trap got=%0b exp=0", trap[0]); end
    send(I_SLLI32, 64'h404);
    checks++; if (trap[2] !== 1'b1 || trap_cause[2] !== 4'd2) begin failures++; $display("[TB] FAIL rv32_slli32 trap=%0b cause=%0d exp trap=1 cause=2", trap[2], trap_cause[2]); end
    checks++; if (alu_op[0] !== 4'd6 || imm[0] !== 64'd32 || trap[0] !== 1'b0) begin failures++; $display("[TB] FAIL rv64_slli32 alu=%0d imm=%0h trap=%0b exp 6/20/0", alu_op[0], imm[0], trap[0]); end
    send(I_LD, 64'h408);
    checks++; if (trap[2] !== 1'b1 || trap_cause[2] !== 4'd2 || mem_read[2] !== 1'b0) begin failures++; $display("[TB] FAIL rv32_ld trap=%0b cause=%0d rd=%0b exp 1/2/0", trap[2], trap_cause[2], mem_read[2]); end
    checks++; if (mem_read[0] !== 1'b1 || alu_op[0] !== 4'd1 || imm[0] !== 64'd8) begin failures++; $display("[TB] FAIL rv64_ld mem_read=%0b alu=%0d imm=%0h exp 1/1/8", mem_read[0], alu_op[0], imm[0]); end
  endtask

  task automatic test_m_and_system();
    send(I_MUL, 64'h500);
    checks++; if (trap[1] !== 1'b1 || trap_cause[1] !== 4'd2 || alu_op[1] !== 4'd0) begin failures++; $display("[TB] FAIL nom_mul trap=%0b cause=%0d alu=%0d exp 1/2/0", trap[1], trap_cause[1], alu_op[1]); end
    checks++; if (alu_op[0] !== 4'd11 || trap[0] !== 1'b0) begin failures++; $display("[TB] FAIL m_mul alu=%0d trap=%0b exp 11/0", alu_op[0], trap[0]); end
    send(I_ECALL, 64'h504);
    checks++; if (trap[0] !== 1'b1 || trap_cause[0] !== 4'd11 || reg_wr[0] !== 1'b0) begin failures++; $display("[TB] FAIL ecall trap=%0b cause=%0d reg_wr=%0b exp 1/11/0", trap[0], trap_cause[0], reg_wr[0]); end
    send(I_EBREAK, 64'h508);
    checks++; if (trap[0] !== 1'b1 || trap_cause[0] !== 4'd3) begin failures++; $display("[TB] FAIL ebreak trap=%0b cause=%0d exp 1/3", trap[0], trap_cause[0]); end
    send(I_CSRRS, 64'h50C);
    checks++; if (is_csr[0] !== 1'b1 || csr_read[0] !== 1'b1 || csr_write[0] !== 1'b0) begin failures++; $display("[TB] FAIL csrrs csr=%0b rd=%0b wr=%0b exp 1/1/0", is_csr[0], csr_read[0], csr_write[0]); end
    checks++; if (reg_wr[0] !== 1'b0 || csr_addr[0] !== 12'h300 || trap[0] !== 1'b0) begin failures++; $display("[TB] FAIL csrrs_misc reg_wr=%0b addr=%0h trap=%0b exp 0/300/0", reg_wr[0], csr_addr[0], trap[0]); end
    send(32'h0000_0000, 64'h510);
    checks++; if (trap[0] !== 1'b1 || trap_cause[0] !== 4'd2) begin failures++; $display("[TB] FAIL compressed trap=%0b cause=%0d exp 1/2", trap[0], trap_cause[0]); end
  endtask

  task automatic test_formats();
    send(I_JAL, 64'h600);
    checks++; if (jump[0] !== 1'b1 || use_pc[0] !== 1'b1 || reg_wr[0] !== 1'b1 || alu_op[0] !== 4'd1) begin failures++; $display("[TB] FAIL jal_ctl jump=%0b use_pc=%0b reg_wr=%0b alu=%0d exp 1/1/1/1", jump[0], use_pc[0], reg_wr[0], alu_op[0]); end
    checks++; if (imm[0] !== 64'd8 || rd[0] !== 5'd1) begin failures++; $display("[TB] FAIL jal_imm imm=%0h rd=%0d exp 8/1", imm[0], rd[0]); end
    send(I_BEQ, 64'h604);
    checks++; if (is_branch[0] !== 1'b1 || alu_op[0] !== 4'd0 || reg_wr[0] !== 1'b0) begin failures++; $display("[TB] FAIL beq_ctl br=%0b alu=%0d reg_wr=%0b exp 1/0/0", is_branch[0], alu_op[0], reg_wr[0]); end
    checks++; if (imm[0] !== 64'hFFFF_FFFF_FFFF_FFFC || rs1[0] !== 5'd1 || rs2[0] !== 5'd2) begin failures++; $display("[TB] FAIL beq_imm imm=%0h rs1=%0d rs2=%0d exp fffffffffffffffc/1/2", imm[0], rs1[0], rs2[0]); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_midstream();
    test_xlen();
    test_m_and_system();
    test_formats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
